// File: rtl/arm_dp_pkg.sv
// Shared types for the ARM data-processing decode stage: opcode and condition
// enums, ALU op codes, the ALU control bundle and the opcode decode function.
package arm_dp_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'd0,  OP_EOR = 4'd1,  OP_SUB = 4'd2,  OP_RSB = 4'd3,
        OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SBC = 4'd6,  OP_RSC = 4'd7,
        OP_TST = 4'd8,  OP_TEQ = 4'd9,  OP_CMP = 4'd10, OP_CMN = 4'd11,
        OP_ORR = 4'd12, OP_MOV = 4'd13, OP_BIC = 4'd14, OP_MVN = 4'd15
    } opcode_e;

    // 4'b1111 (NV) is deliberately absent and evaluates as never.
    typedef enum logic [3:0] {
        CC_EQ = 4'd0,  CC_NE = 4'd1,  CC_CS = 4'd2,  CC_CC = 4'd3,
        CC_MI = 4'd4,  CC_PL = 4'd5,  CC_VS = 4'd6,  CC_VC = 4'd7,
        CC_HI = 4'd8,  CC_LS = 4'd9,  CC_GE = 4'd10, CC_LT = 4'd11,
        CC_GT = 4'd12, CC_LE = 4'd13, CC_AL = 4'd14
    } cond_e;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0111;
    localparam logic [3:0] ALU_ORR   = 4'b1000;
    localparam logic [3:0] ALU_XOR   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    typedef struct packed {
        logic [3:0] op;
        logic       swap;
        logic       inv_b;
        logic       use_carry;
        logic       res_we;
        logic       flags_we;
    } alu_ctrl_t;

    function automatic alu_ctrl_t dp_decode(input logic [3:0] opc, input logic s);
        alu_ctrl_t c;
        c          = '0;
        c.res_we   = 1'b1;
        c.flags_we = s;
        case (opcode_e'(opc))
            OP_AND, OP_TST: c.op = ALU_AND;
            OP_EOR, OP_TEQ: c.op = ALU_XOR;
            OP_SUB, OP_CMP: c.op = ALU_SUB;
            OP_RSB: begin c.op = ALU_SUB; c.swap = 1'b1; end
            OP_ADD, OP_CMN: c.op = ALU_ADD;
            OP_ADC: begin c.op = ALU_ADD; c.use_carry = 1'b1; end
            OP_SBC: begin c.op = ALU_SUB; c.use_carry = 1'b1; end
            OP_RSC: begin c.op = ALU_SUB; c.swap = 1'b1; c.use_carry = 1'b1; end
            OP_ORR: c.op = ALU_ORR;
            OP_MOV: c.op = ALU_PASSB;
            OP_BIC: begin c.op = ALU_AND; c.inv_b = 1'b1; end
            OP_MVN: begin c.op = ALU_PASSB; c.inv_b = 1'b1; end
            default: c.op = ALU_ADD;
        endcase
        // TST/TEQ/CMP/CMN: compare-only, always write flags, never Rd
        if (opc[3:2] == 2'b10) begin
            c.res_we   = 1'b0;
            c.flags_we = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/arm_cond_eval.sv
// Combinational ARM condition-code check of cond against flags {N,Z,C,V}.
module arm_cond_eval
    import arm_dp_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);
    logic n, z, c, v;
    assign {n, z, c, v} = nzcv;

    always_comb begin
        pass = 1'b0;
        case (cond)
            CC_EQ: pass = z;
            CC_NE: pass = !z;
            CC_CS: pass = c;
            CC_CC: pass = !c;
            CC_MI: pass = n;
            CC_PL: pass = !n;
            CC_VS: pass = v;
            CC_VC: pass = !v;
            CC_HI: pass = c && !z;
            CC_LS: pass = !c || z;
            CC_GE: pass = (n == v);
            CC_LT: pass = (n != v);
            CC_GT: pass = !z && (n == v);
            CC_LE: pass = z || (n != v);
            CC_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/arm_dp_decode_stage.sv
// Registered ARM data-processing decode stage with valid/ready handshake.
// Define COND_EXEC_EN to enable condition evaluation and the nullified counter.
module arm_dp_decode_stage
    import arm_dp_pkg::*;
#(
    parameter int ALU_CTRL_W = 4,
    parameter int TAG_W      = 8,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            opcode_i,
    input  logic [3:0]            cond_i,
    input  logic                  s_bit_i,
    input  logic [TAG_W-1:0]      tag_i,
    input  logic [3:0]            nzcv_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ALU_CTRL_W-1:0] alu_op_o,
    output logic                  swap_ops_o,
    output logic                  inv_b_o,
    output logic                  use_carry_o,
    output logic                  res_we_o,
    output logic                  flags_we_o,
    output logic [TAG_W-1:0]      tag_o,
    output logic [CNT_W-1:0]      nullified_cnt_o
);
    localparam int STAGES = 1;

    logic [STAGES:1]  vld_pipe;
    logic             accept;
    logic             pass;
    alu_ctrl_t        dec, ctrl_q;
    logic [TAG_W-1:0] tag_q;

    assign in_ready = !vld_pipe[STAGES] || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef COND_EXEC_EN
    logic [CNT_W-1:0] null_cnt;

    arm_cond_eval u_cond (
        .cond (cond_i),
        .nzcv (nzcv_i),
        .pass (pass)
    );

    always_ff @(posedge clk) begin
        if (rst)
            null_cnt <= '0;
        else if (accept && !pass && null_cnt != {CNT_W{1'b1}})
            null_cnt <= null_cnt + 1'b1;
    end

    assign nullified_cnt_o = null_cnt;
`else
    logic unused_cond;
    assign unused_cond     = ^{cond_i, nzcv_i};
    assign pass            = 1'b1;
    assign nullified_cnt_o = '0;
`endif

    // A failed condition still issues a bundle so the tag reaches the ALU stage.
    always_comb begin
        dec = dp_decode(opcode_i, s_bit_i);
        if (!pass) begin
            dec.res_we   = 1'b0;
            dec.flags_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            ctrl_q   <= '0;
            tag_q    <= '0;
        end else if (accept) begin
            vld_pipe[1] <= 1'b1;
            ctrl_q      <= dec;
            tag_q       <= tag_i;
        end else if (out_ready) begin
            vld_pipe[1] <= 1'b0;
        end
    end

    assign out_valid   = vld_pipe[STAGES];
    assign alu_op_o    = ALU_CTRL_W'(ctrl_q.op);
    assign swap_ops_o  = ctrl_q.swap;
    assign inv_b_o     = ctrl_q.inv_b;
    assign use_carry_o = ctrl_q.use_carry;
    assign res_we_o    = ctrl_q.res_we;
    assign flags_we_o  = ctrl_q.flags_we;
    assign tag_o       = tag_q;
endmodule

// File: tb/tb_arm_dp_decode_stage.sv
// Directed table-driven bench for arm_dp_decode_stage; cond tests follow COND_EXEC_EN.
module tb_arm_dp_decode_stage;
    localparam int TAG_W = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [3:0]       opcode_i, cond_i, nzcv_i;
    logic             s_bit_i;
    logic [TAG_W-1:0] tag_i, tag_o;
    logic [3:0]       alu_op_o;
    logic             swap_ops_o, inv_b_o, use_carry_o, res_we_o, flags_we_o;
    logic [CNT_W-1:0] nullified_cnt_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    arm_dp_decode_stage #(.ALU_CTRL_W(4), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode_i(opcode_i), .cond_i(cond_i), .s_bit_i(s_bit_i),
        .tag_i(tag_i), .nzcv_i(nzcv_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_op_o(alu_op_o), .swap_ops_o(swap_ops_o), .inv_b_o(inv_b_o),
        .use_carry_o(use_carry_o), .res_we_o(res_we_o), .flags_we_o(flags_we_o),
        .tag_o(tag_o), .nullified_cnt_o(nullified_cnt_o)
    );

    typedef struct {
        logic [3:0] opc;
        logic       s;
        logic [3:0] aop;
        logic       swap, inv, car, res, fl;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, then look at outputs just after the rising edge.
    task automatic step(input logic v, input logic [3:0] opc, input logic s,
                        input logic [3:0] cnd, input logic [3:0] f,
                        input logic [TAG_W-1:0] t, input logic ordy);
        @(negedge clk);
        in_valid = v; opcode_i = opc; s_bit_i = s; cond_i = cnd;
        nzcv_i = f; tag_i = t; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bundle(input string name, input vec_t e);
        chk({name, ".op"},    {28'd0, alu_op_o}, {28'd0, e.aop});
        chk({name, ".ctl"},   {27'd0, swap_ops_o, inv_b_o, use_carry_o, res_we_o, flags_we_o},
                              {27'd0, e.swap, e.inv, e.car, e.res, e.fl});
    endtask

    initial begin
        //          opc   s  aop     sw inv car res fl
        vecs[0]  = '{4'd0,  0, 4'b0111, 0, 0, 0, 1, 0};
        vecs[1]  = '{4'd1,  0, 4'b1001, 0, 0, 0, 1, 0};
        vecs[2]  = '{4'd2,  0, 4'b0001, 0, 0, 0, 1, 0};
        vecs[3]  = '{4'd3,  0, 4'b0001, 1, 0, 0, 1, 0};
        vecs[4]  = '{4'd4,  0, 4'b0000, 0, 0, 0, 1, 0};
        vecs[5]  = '{4'd5,  0, 4'b0000, 0, 0, 1, 1, 0};
        vecs[6]  = '{4'd6,  0, 4'b0001, 0, 0, 1, 1, 0};
        vecs[7]  = '{4'd7,  0, 4'b0001, 1, 0, 1, 1, 0};
        vecs[8]  = '{4'd8,  0, 4'b0111, 0, 0, 0, 0, 1};
        vecs[9]  = '{4'd9,  0, 4'b1001, 0, 0, 0, 0, 1};
        vecs[10] = '{4'd10, 0, 4'b0001, 0, 0, 0, 0, 1};
        vecs[11] = '{4'd11, 0, 4'b0000, 0, 0, 0, 0, 1};
        vecs[12] = '{4'd12, 0, 4'b1000, 0, 0, 0, 1, 0};
        vecs[13] = '{4'd13, 0, 4'b1010, 0, 0, 0, 1, 0};
        vecs[14] = '{4'd14, 0, 4'b0111, 0, 1, 0, 1, 0};
        vecs[15] = '{4'd15, 0, 4'b1010, 0, 1, 0, 1, 0};
        vecs[16] = '{4'd4,  1, 4'b0000, 0, 0, 0, 1, 1};
        vecs[17] = '{4'd10, 1, 4'b0001, 0, 0, 0, 0, 1};
        vecs[18] = '{4'd15, 1, 4'b1010, 0, 1, 0, 1, 1};

        rst = 1'b1; in_valid = 1'b1; opcode_i = 4'd4; s_bit_i = 1'b1;
        cond_i = 4'he; nzcv_i = 4'h0; tag_i = 8'h11; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.cnt",       {28'd0, nullified_cnt_o}, 32'd0);
        chk("rst.tag",       {24'd0, tag_o}, 32'd0);
        chk("rst.op",        {27'd0, alu_op_o, res_we_o}, 32'd0);

        // first accept on the edge after reset falls
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("first.out_valid", {31'd0, out_valid}, 32'd1);
        chk("first.tag",       {24'd0, tag_o}, 32'h11);

        // opcode sweep under AL, back to back
        for (int i = 0; i < 19; i++) begin
            step(1'b1, vecs[i].opc, vecs[i].s, 4'he, 4'h0, 8'(8'h40 + i), 1'b1);
            chk($sformatf("vec%0d.valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("vec%0d.tag", i), {24'd0, tag_o}, 32'(8'h40 + i));
            chk_bundle($sformatf("vec%0d", i), vecs[i]);
        end

        // backpressure: hold RSC bundle for 3 cycles
        step(1'b1, 4'd7, 1'b0, 4'he, 4'h0, 8'hA5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'd13, 1'b0, 4'he, 4'h0, 8'hB6, 1'b0);
            chk($sformatf("stall%0d.in_ready", i), {31'd0, in_ready}, 32'd0);
            chk($sformatf("stall%0d.valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("stall%0d.tag", i), {24'd0, tag_o}, 32'hA5);
            chk_bundle($sformatf("stall%0d", i), vecs[7]);
        end
        step(1'b1, 4'd13, 1'b0, 4'he, 4'h0, 8'hB6, 1'b1);
        chk("replace.valid", {31'd0, out_valid}, 32'd1);
        chk("replace.tag",   {24'd0, tag_o}, 32'hB6);
        chk_bundle("replace", vecs[13]);
        step(1'b1, 4'd14, 1'b0, 4'he, 4'h0, 8'hC7, 1'b1);
        chk("next.tag", {24'd0, tag_o}, 32'hC7);
        chk_bundle("next", vecs[14]);
        step(1'b0, 4'd0, 1'b0, 4'he, 4'h0, 8'h00, 1'b1);
        chk("drain.valid",    {31'd0, out_valid}, 32'd0);
        chk("drain.in_ready", {31'd0, in_ready}, 32'd1);

`ifdef COND_EXEC_EN
        step(1'b1, 4'd4, 1'b1, 4'h0, 4'h0, 8'hD1, 1'b1);
        chk("eqfail.valid", {31'd0, out_valid}, 32'd1);
        chk("eqfail.we",    {30'd0, res_we_o, flags_we_o}, 32'd0);
        chk("eqfail.tag",   {24'd0, tag_o}, 32'hD1);
        chk("eqfail.cnt",   {28'd0, nullified_cnt_o}, 32'd1);
        step(1'b1, 4'd4, 1'b1, 4'h0, 4'h4, 8'hD2, 1'b1);
        chk("eqpass.we",    {30'd0, res_we_o, flags_we_o}, 32'd3);
        chk("eqpass.cnt",   {28'd0, nullified_cnt_o}, 32'd1);
        // GT fails with Z set; LT passes with N!=V
        step(1'b1, 4'd2, 1'b1, 4'hc, 4'h4, 8'hD3, 1'b1);
        chk("gtfail.we",    {30'd0, res_we_o, flags_we_o}, 32'd0);
        chk("gtfail.cnt",   {28'd0, nullified_cnt_o}, 32'd2);
        step(1'b1, 4'd2, 1'b1, 4'hb, 4'h8, 8'hD4, 1'b1);
        chk("ltpass.we",    {30'd0, res_we_o, flags_we_o}, 32'd3);
        for (int i = 0; i < 20; i++)
            step(1'b1, 4'd4, 1'b0, 4'hf, 4'hf, 8'(i), 1'b1);
        chk("sat.cnt",   {28'd0, nullified_cnt_o}, 32'd15);
        chk("sat.valid", {31'd0, out_valid}, 32'd1);
        chk("sat.we",    {30'd0, res_we_o, flags_we_o}, 32'd0);
`else
        step(1'b1, 4'd4, 1'b1, 4'hf, 4'h0, 8'hE1, 1'b1);
        chk("nv.we",   {30'd0, res_we_o, flags_we_o}, 32'd3);
        chk("nv.cnt",  {28'd0, nullified_cnt_o}, 32'd0);
        step(1'b1, 4'd10, 1'b0, 4'h0, 4'h0, 8'hE2, 1'b1);
        chk("eq.we",   {30'd0, res_we_o, flags_we_o}, 32'd1);
        chk("eq.cnt",  {28'd0, nullified_cnt_o}, 32'd0);
`endif

        // reset while a bundle is held discards it
        step(1'b1, 4'd4, 1'b0, 4'he, 4'h0, 8'hF0, 1'b0);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst.valid", {31'd0, out_valid}, 32'd0);
        chk("midrst.tag",   {24'd0, tag_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
